// File: rtl/bidir_line_ctrl.sv
// Two-requester arbiter driving a half-duplex serial line: send a byte, turn the bus, receive a byte.
// Define BIDIR_LINE_PARITY_EN to add a 9th odd-parity bit in both directions and report mismatches on err.
module bidir_line_ctrl #(
  parameter int BIT_CYCLES  = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       err,
  inout  wire        line_io
);

`ifdef BIDIR_LINE_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam int PMAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int BW   = $clog2(NBITS);

  localparam logic [PW-1:0] PH_ONE     = PW'(1);
  localparam logic [PW-1:0] BIT_LAST   = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] TURN_LAST  = PW'(TURN_CYCLES - 1);
  localparam logic [PW-1:0] SAMPLE_PH  = PW'(BIT_CYCLES / 2);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [BW-1:0] FRAME_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_b_q, owner_b_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [NBITS-1:0]  txsh_q, txsh_d;
  logic [NBITS-1:0]  rxsh_q, rxsh_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  function automatic logic [NBITS-1:0] build_frame(input logic [7:0] b);
`ifdef BIDIR_LINE_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

  function automatic logic frame_parity_bad(input logic [NBITS-1:0] f);
`ifdef BIDIR_LINE_PARITY_EN
    return f[0] != ~^f[8:1];
`else
    return 1'b0;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    txsh_d    = txsh_q;
    rxsh_d    = rxsh_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (req_a || req_b) begin
          // owner_b_q doubles as the last-granted side, so a tie goes to the other one
          owner_b_d = req_b && (!req_a || !owner_b_q);
          txsh_d    = owner_b_d ? build_frame(wdata_b) : build_frame(wdata_a);
          rxsh_d    = '0;
          state_d   = TX;
        end
      end
      TX: begin
        phase_d = phase_q + PH_ONE;
        if (phase_q == BIT_LAST) begin
          phase_d = '0;
          txsh_d  = {txsh_q[NBITS-2:0], 1'b0};
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == FRAME_LAST) begin
            bit_d   = '0;
            state_d = TURN;
          end
        end
      end
      TURN: begin
        phase_d = phase_q + PH_ONE;
        if (phase_q == TURN_LAST) begin
          phase_d = '0;
          state_d = RX;
        end
      end
      RX: begin
        phase_d = phase_q + PH_ONE;
        if (phase_q == SAMPLE_PH) begin
          rxsh_d = {rxsh_q[NBITS-2:0], line_io};
        end
        if (phase_q == BIT_LAST) begin
          phase_d = '0;
          bit_d   = bit_q + BIT_ONE;
          if (bit_q == FRAME_LAST) begin
            // results land on entry to DONE so they are valid alongside the done pulse
            bit_d   = '0;
            rdata_d = rxsh_d[NBITS-1 -: 8];
            err_d   = frame_parity_bad(rxsh_d);
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b1;
      phase_q   <= '0;
      bit_q     <= '0;
      rdata_q   <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_b_q <= owner_b_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    txsh_q <= txsh_d;
    rxsh_q <= rxsh_d;
  end

  assign busy    = (state_q != IDLE);
  assign gnt_a   = busy && !owner_b_q;
  assign gnt_b   = busy && owner_b_q;
  assign done_a  = (state_q == DONE) && !owner_b_q;
  assign done_b  = (state_q == DONE) && owner_b_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign line_io = (state_q == TX) ? txsh_q[NBITS-1] : 1'bz;

endmodule
